// File: rtl/lsu_handshake.sv
// Load/store unit driving a req/gnt/rvalid data-memory bus, with lane alignment and load extension.
// Define LSU_TIMEOUT_EN to fault accesses that wait TIMEOUT_CYCLES for gnt or rvalid.
module lsu_handshake #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [4:0]              rd_i,
  output logic                    stall_o,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [4:0]              rd_o,
  output logic                    load_err_o,
  output logic                    store_err_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_LWU = 4'd6, OP_LD = 4'd7, OP_SB = 4'd8,
                         OP_SH = 4'd9, OP_SW = 4'd10, OP_SD = 4'd11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Access size in bytes; 0 marks NONE and ops reserved for this data width.
  function automatic logic [3:0] op_bytes(input logic [3:0] op);
    logic [3:0] n;
    case (op)
      OP_LB, OP_LBU, OP_SB:  n = 4'd1;
      OP_LH, OP_LHU, OP_SH:  n = 4'd2;
      OP_LW, OP_SW:          n = 4'd4;
      OP_LWU:                n = (DATA_WIDTH == 64) ? 4'd4 : 4'd0;
      OP_LD, OP_SD:          n = (DATA_WIDTH == 64) ? 4'd8 : 4'd0;
      default:               n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic is_signed_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic is_aligned(input logic [3:0] nbytes, input logic [2:0] lo);
    logic [3:0] m;
    m = nbytes - 4'd1;
    return (lo & m[2:0]) == 3'd0;
  endfunction

  function automatic logic [NB-1:0] build_be(input logic [3:0] nbytes, input logic [LANE_W-1:0] lane);
    logic [NB-1:0] be;
    for (int i = 0; i < NB; i++)
      be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(nbytes));
    return be;
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend above the access size.
  function automatic logic signed [DATA_WIDTH-1:0] load_align(input logic [3:0] nbytes, input logic sgn,
                                                              input logic [DATA_WIDTH-1:0] data,
                                                              input logic [LANE_W-1:0] lane);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [DATA_WIDTH-1:0] res;
    int nbits;
    sh = data >> {lane, 3'b000};
    nbits = int'(nbytes) * 8;
    if (nbits == 0 || nbits > DATA_WIDTH) nbits = DATA_WIDTH;
    for (int i = 0; i < DATA_WIDTH; i++)
      res[i] = (i < nbits) ? sh[i] : (sgn & sh[nbits-1]);
    return res;
  endfunction

  state_t                       state, state_nxt;
  logic [3:0]                   op_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [4:0]                   rd_q;
  logic signed [DATA_WIDTH-1:0] rdata_q;
  logic                         err_q;
  logic [3:0]                   req_bytes;
  logic [LANE_W-1:0]            lane;
  logic                         ok_align, accept, beat, fault;

  assign req_bytes = op_bytes(mem_op_i);
  assign ok_align  = is_aligned(req_bytes, addr_i[2:0]);
  assign accept    = (state == IDLE) && req_valid_i && (req_bytes != 4'd0);
  assign beat      = (((state == REQ) && dmem_gnt_i) || (state == WAIT)) && dmem_rvalid_i;
  assign lane      = addr_q[LANE_W-1:0];

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wait_cnt <= '0;
    else if (state_nxt != state)             wait_cnt <= '0;
    else if (state == REQ || state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  // A grant or beat arriving in the final cycle still wins over the timeout.
  assign fault = ((state == REQ && !dmem_gnt_i) || (state == WAIT && !dmem_rvalid_i)) &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)     err_q <= !ok_align;
      else if (fault) err_q <= 1'b1;
    end
  end

  // Capture stage: op fields on accept, extended load data on the read beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= mem_op_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      rd_q    <= rd_i;
      rdata_q <= '0;
    end else if (beat && !is_store(op_q)) begin
      rdata_q <= load_align(op_bytes(op_q), is_signed_load(op_q), dmem_rdata_i, lane);
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    stall_o      = 1'b1;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    resp_valid_o = 1'b0;
    rdata_o      = '0;
    rd_o         = '0;
    load_err_o   = 1'b0;
    store_err_o  = 1'b0;
    err_addr_o   = '0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = 1'b0;
        if (accept) state_nxt = ok_align ? REQ : RESP;
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = is_store(op_q);
        dmem_addr_o  = {addr_q[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
        dmem_be_o    = build_be(op_bytes(op_q), lane);
        dmem_wdata_o = wdata_q << {lane, 3'b000};
        if (dmem_gnt_i) state_nxt = dmem_rvalid_i ? RESP : WAIT;
        else if (fault) state_nxt = RESP;
      end
      WAIT: begin
        if (dmem_rvalid_i || fault) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        rdata_o      = rdata_q;
        rd_o         = rd_q;
        load_err_o   = err_q && !is_store(op_q);
        store_err_o  = err_q && is_store(op_q);
        err_addr_o   = err_q ? addr_q : '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake: a per-cycle reference model of one outstanding op
// checks handshake, bus and response outputs; literal expectations pin the model.
module tb_lsu_handshake;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req_valid, req_ready, stall, resp_valid;
  logic [3:0]    mem_op;
  logic [AW-1:0] addr, err_addr, dmem_addr;
  logic [DW-1:0] wdata, rdata, dmem_wdata, dmem_rdata;
  logic [4:0]    rd, rd_out;
  logic          load_err, store_err, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]    dmem_be;

  lsu_handshake #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata), .rd_i(rd), .stall_o(stall),
    .resp_valid_o(resp_valid), .rdata_o(rdata), .rd_o(rd_out), .load_err_o(load_err),
    .store_err_o(store_err), .err_addr_o(err_addr), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected behaviour of the op in flight, set when it is accepted.
  int          p_cyc = -100;
  int          exp_lat = 0;
  int          n_req = 0;
  logic [31:0] e_addr_al, e_wdata, e_rdata, e_eaddr;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic        e_we, e_lerr, e_serr, e_err;
  bit          resp_seen;
  int          last_lat;
  logic [31:0] last_rdata, last_wd, last_eaddr;
  logic [3:0]  last_be;
  logic        last_we, last_lerr, last_serr;

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd8: return 1;
      4'd2, 4'd5, 4'd9: return 2;
      4'd3, 4'd10:      return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return op >= 4'd8 && op <= 4'd10;
  endfunction

  function automatic bit op_sgn(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd3;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    int n, ln;
    logic [63:0] v, mask;
    n = op_size(op);
    ln = int'(a[1:0]);
    v = {32'b0, d} >> (8 * ln);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (op_sgn(op) && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  int mk;
  always @(negedge clk) begin
    mk = cyc - p_cyc;
    chk("stall_o", stall, mk >= 1 && mk <= exp_lat);
    chk("req_ready_o", req_ready, !(mk >= 1 && mk <= exp_lat));
    chk("dmem_req_o", dmem_req, mk >= 1 && mk <= n_req);
    chk("resp_valid_o", resp_valid, mk == exp_lat);
    if (dmem_req && mk >= 1 && mk <= n_req) begin
      chk("dmem_addr_o", dmem_addr, e_addr_al);
      chk("dmem_be_o", dmem_be, e_be);
      chk("dmem_we_o", dmem_we, e_we);
      if (e_we) chk("dmem_wdata_o", dmem_wdata, e_wdata);
      last_be = dmem_be; last_wd = dmem_wdata; last_we = dmem_we;
    end
    if (resp_valid && mk == exp_lat) begin
      chk("rdata_o", rdata, e_rdata);
      chk("rd_o", rd_out, e_rd);
      chk("load_err_o", load_err, e_lerr);
      chk("store_err_o", store_err, e_serr);
      if (e_err) chk("err_addr_o", err_addr, e_eaddr);
      last_rdata = rdata; last_lerr = load_err; last_serr = store_err;
      last_eaddr = err_addr; last_lat = mk;
      resp_seen = 1'b1;
    end
  end

  // g: REQ cycles before gnt; r: cycles from gnt to rvalid (0 = same cycle).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int g, input int r, input logic [4:0] tag);
    bit timed;
    int k;
    @(negedge clk);
    mem_op = op; addr = a; wdata = wd; rd = tag; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_op = 4'd0;
    e_err = (a % op_size(op)) != 0;
    timed = TO_ON && !e_err && g >= TO;
    e_addr_al = a & ~32'd3;
    e_be = 4'((32'd1 << op_size(op)) - 32'd1) << a[1:0];
    e_wdata = wd << (8 * int'(a[1:0]));
    e_we = op_store(op);
    e_rd = tag;
    e_lerr = (e_err || timed) && !op_store(op);
    e_serr = (e_err || timed) && op_store(op);
    e_eaddr = a;
    e_rdata = (op_store(op) || e_err || timed) ? 32'd0 : model_load(op, a, rdat);
    if (e_err)      begin n_req = 0;   exp_lat = 1;      end
    else if (timed) begin n_req = TO;  exp_lat = TO + 1; end
    else            begin n_req = g+1; exp_lat = g + 2 + r; end
    resp_seen = 1'b0;
    p_cyc = cyc - 1;
    k = 0;
    while (!resp_seen && k < 60) begin
      dmem_gnt = !e_err && k == g;
      dmem_rvalid = !e_err && k == g + r;
      dmem_rdata = rdat;
      @(posedge clk); #1;
      k++;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!resp_seen) begin
      n_chk++;
      $display("FAIL resp_timeout: got no response, expected one within 60 cycles");
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_op = 4'd0; addr = '0; wdata = '0; rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    do_op(4'd3, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 5'd5);
    chk("lw_rdata", last_rdata, 32'hDEADBEEF);
    chk("lw_latency", last_lat, 2);
    do_op(4'd1, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 5'd6);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    do_op(4'd4, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 5'd7);
    chk("lbu_rdata", last_rdata, 32'h00000080);
    do_op(4'd9, 32'h202, 32'h1234ABCD, 32'h5555_5555, 1, 1, 5'd8);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wd, 32'hABCD0000);
    chk("sh_we", last_we, 1'b1);
    chk("sh_rdata", last_rdata, 32'd0);
    do_op(4'd3, 32'h101, 32'h0, 32'h0, 0, 0, 5'd9);
    chk("mis_lw_err", last_lerr, 1'b1);
    chk("mis_lw_addr", last_eaddr, 32'h101);
    chk("mis_lw_latency", last_lat, 1);
    do_op(4'd3, 32'h300, 32'h0, 32'h0BADF00D, 3, 2, 5'd10);
    chk("slow_latency", last_lat, 7);
    chk("slow_rdata", last_rdata, 32'h0BADF00D);
    do_op(4'd2, 32'h102, 32'h0, 32'h8001_0000, 0, 1, 5'd11);
    chk("lh_rdata", last_rdata, 32'hFFFF8001);
    do_op(4'd5, 32'h106, 32'h0, 32'hFFEE_0000, 2, 0, 5'd12);
    chk("lhu_rdata", last_rdata, 32'h0000FFEE);
    do_op(4'd8, 32'h203, 32'h000000AA, 32'h0, 0, 0, 5'd13);
    chk("sb_be", last_be, 4'b1000);
    chk("sb_wdata", last_wd, 32'hAA000000);
    do_op(4'd10, 32'h204, 32'hCAFEF00D, 32'h0, 2, 0, 5'd14);
    chk("sw_be", last_be, 4'b1111);
    do_op(4'd9, 32'h201, 32'h1111, 32'h0, 0, 0, 5'd15);
    chk("mis_sh_err", last_serr, 1'b1);
    chk("mis_sh_lerr", last_lerr, 1'b0);

    // Reserved and NONE ops must not be accepted.
    @(negedge clk);
    mem_op = 4'd7; addr = 32'h0; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rsvd_ready", req_ready, 1'b1);
    mem_op = 4'd0;
    repeat (2) @(negedge clk);
    chk("none_stall", stall, 1'b0);
    req_valid = 1'b0;

    // Reset while waiting for gnt, then a stray rvalid.
    @(negedge clk);
    mem_op = 4'd10; addr = 32'h400; wdata = 32'h600DD00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_op = 4'd0;
    e_err = 1'b0; e_we = 1'b1; e_addr_al = 32'h400; e_be = 4'hF; e_wdata = 32'h600DD00D;
    n_req = 1000; exp_lat = 1000; p_cyc = cyc - 1;
    @(negedge clk);
    chk("pre_rst_req", dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    p_cyc = -100; exp_lat = 0; n_req = 0;
    #1;
    chk("rst_async_req", dmem_req, 1'b0);
    chk("rst_async_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_rvalid_resp", resp_valid, 1'b0);

    do_op(4'd3, 32'h108, 32'h0, 32'h13579BDF, 0, 0, 5'd16);
    chk("post_rst_rdata", last_rdata, 32'h13579BDF);

`ifdef LSU_TIMEOUT_EN
    do_op(4'd10, 32'h500, 32'h12345678, 32'h0, 999, 0, 5'd17);
    chk("to_store_err", last_serr, 1'b1);
    chk("to_err_addr", last_eaddr, 32'h500);
    chk("to_latency", last_lat, TO + 1);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit replacing the fixed-latency MEM-stage memory path.
- Accepts one memory op per transaction from the pipeline and drives a request/grant/rvalid data-memory bus, so memories of any latency are supported.
- Aligns and extends load data and builds byte-enable/write data for stores.
- Flags misaligned accesses and stalls the pipeline while an access is in flight.
- Supports 32- and 64-bit data paths.

Parameters:
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 255, cycles of waiting on gnt or rvalid before bus fault; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline op valid
- req_ready_o  out  1  LSU idle, can accept
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD; others reserved
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  store data, LSB-aligned
- rd_i  in  5  destination register tag
- stall_o  out  1  high while busy, i.e. whenever state != IDLE
- resp_valid_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rd_o  out  5  tag of completed op
- load_err_o  out  1  misaligned or faulted load, valid with resp_valid_o
- store_err_o  out  1  misaligned or faulted store, valid with resp_valid_o
- err_addr_o  out  ADDR_WIDTH  address of the failing op
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  write
- dmem_addr_o  out  ADDR_WIDTH  address aligned to DATA_WIDTH/8
- dmem_be_o  out  DATA_WIDTH/8  byte enables
- dmem_wdata_o  out  DATA_WIDTH  lane-shifted write data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid / write acknowledge
- dmem_rdata_i  in  DATA_WIDTH  read data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, state goes to IDLE and every output is 0, except req_ready_o=1.
- FSM states IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accept when req_valid_i && req_ready_o && op != NONE. Capture op, addr, wdata, rd.
  - If aligned, go to REQ. Otherwise go to RESP with an error.
  - NONE and reserved ops are ignored; they are not accepted.
- Alignment rules:
  - Halfword ops need addr[0]=0.
  - Word ops need addr[1:0]=0.
  - D ops need addr[2:0]=0.
  - With DATA_WIDTH=32, LD, SD and LWU are reserved.
- REQ:
  - dmem_req_o=1; addr, be, wdata and we are held stable until dmem_gnt_i.
  - On gnt, go to WAIT. If dmem_rvalid_i is also high in the grant cycle, go straight to RESP.
- WAIT: on dmem_rvalid_i, go to RESP. Load data is latched from dmem_rdata_i.
- RESP:
  - resp_valid_o=1 for exactly one cycle, with rdata_o, rd_o and the error flags registered.
  - Next state is IDLE. A new op can be accepted the cycle after RESP.
- Minimum latency: accept to resp_valid_o is 2 cycles with gnt and rvalid in the REQ cycle. A misaligned op takes 1 cycle.
- Lane = addr[log2(DATA_WIDTH/8)-1:0].
- Store byte enables: SB gives 1 bit at the lane; SH gives 2 bits; SW gives 4 bits; SD gives all bits. wdata is shifted left by lane*8.
- Loads: data is shifted right by lane*8, then sign-extended for LB, LH, LW(64) or zero-extended for LBU, LHU, LWU.
- Stores return rdata_o=0 and ignore dmem_rdata_i.
- Error response: no bus access is made, rdata_o=0, err_addr_o=captured addr, and exactly one of load_err_o or store_err_o is set.
- req_ready_o is 1 only in IDLE.
- stall_o is combinational from state.
- Reset mid-transaction: the FSM returns to IDLE and drops dmem_req_o. A late rvalid while in IDLE is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter, sized to hold TIMEOUT_CYCLES, counts cycles spent in REQ or WAIT and clears on each state entry.
  - On reaching TIMEOUT_CYCLES, go to RESP with load_err_o or store_err_o set and err_addr_o=addr; dmem_req_o drops.
- When undefined: no counter; the LSU waits indefinitely.

Test Plan:
- LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> resp_valid_o 2 cycles after accept, rdata_o=0xDEADBEEF, stall_o high 2 cycles.
- LB addr 0x103, rdata 0x80FF_0000 -> rdata_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> dmem_be_o=4'b1100, dmem_wdata_o=0xABCD0000, dmem_we_o=1, rdata_o=0.
- LW addr 0x101 -> no dmem_req_o, resp next cycle, load_err_o=1, err_addr_o=0x101.
- gnt delayed 3 cycles, rvalid 2 more -> dmem_addr_o stable throughout REQ, resp_valid_o 1 cycle after rvalid, req_ready_o low until IDLE.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, gnt never asserted, SW -> store_err_o=1 after 4 cycles in REQ, dmem_req_o drops.
